// File: rtl/uart_tx_only_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_only_fifo                                          |
// | Description : Byte FIFO feeding an 8N1 UART transmitter. The head byte   |
// |               is visible without a read cycle, so consecutive frames go  |
// |               out with no idle gap. o_tx_ready flags that enough space   |
// |               remains to accept a full line without further handshake.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx_only_fifo #(
  parameter int parm_CLK_HZ     = 20000000,
  parameter int parm_BAUD       = 115200,
  parameter int parm_FIFO_DEPTH = 64,
  parameter int parm_READY_FREE = 34
) (
  input  logic                               i_clk_20mhz,
  input  logic                               i_rstn_20mhz,
  input  logic [7:0]                         i_tx_data,
  input  logic                               i_tx_valid,
  output logic                               o_tx_ready,
  output logic                               eo_uart_tx,
  output logic [$clog2(parm_FIFO_DEPTH):0]   o_fifo_count,
  output logic                               o_busy,
  output logic                               o_overflow
);

  // Address width, baud divider and counter width derived from parameters.
  localparam int c_aw       = $clog2(parm_FIFO_DEPTH);
  localparam int c_baud_div = parm_CLK_HZ / parm_BAUD;
  localparam int c_bw       = (c_baud_div > 1) ? $clog2(c_baud_div) : 1;

  localparam logic [c_bw-1:0] c_baud_last  = c_bw'(c_baud_div - 1);
  localparam logic [c_aw:0]   c_depth      = (c_aw + 1)'(parm_FIFO_DEPTH);
  localparam logic [c_aw:0]   c_ready_free = (c_aw + 1)'(parm_READY_FREE);

  // Serializer states; the line level is held in r_tx, not decoded from state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [parm_FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_tx_ready;
  logic            r_overflow;

  logic            w_full;
  logic            w_not_empty;
  logic            w_wr_en;
  logic            w_wr_drop;
  logic            w_pop;
  logic [7:0]      w_head;
  logic [c_aw:0]   w_count_nxt;
  logic [c_aw:0]   w_free_nxt;
  logic            w_ready_nxt;

  // Serializer registers and their next-state values
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_bw-1:0] r_baud_cnt;
  logic [c_bw-1:0] w_baud_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_tx;
  logic            w_tx_nxt;
  logic            w_bit_end;

  assign w_full      = (r_count == c_depth);
  assign w_not_empty = (r_count != '0);
  // A write into a full FIFO is dropped even when a pop frees a slot on the
  // same edge; fullness is judged on the occupancy before the edge.
  assign w_wr_en     = i_tx_valid && !w_full;
  assign w_wr_drop   = i_tx_valid && w_full;
  // First-word-fall-through: head byte is read combinationally.
  assign w_head      = r_mem[r_rd_ptr];
  assign w_bit_end   = (r_baud_cnt == c_baud_last);

  // Occupancy after this edge, and the ready flag that goes with it.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    w_free_nxt  = c_depth - w_count_nxt;
    w_ready_nxt = (w_free_nxt >= c_ready_free);
  end

  // FIFO data array; contents need no reset since pointers define validity.
  always_ff @(posedge i_clk_20mhz) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_tx_data;
    end
  end

  // FIFO pointers, occupancy, ready flag and sticky overflow.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_ready <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count    <= w_count_nxt;
      r_tx_ready <= w_ready_nxt;
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Serializer state register; reset forces the line high mid-frame.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // Serializer next-state: start bit, 8 data bits LSB first, stop bit.
  // The stop bit end pops the next byte directly so frames run back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = '0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_tx_nxt    = r_shift[0];
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            // Shift so the bit on the line always comes from r_shift[0].
            w_bit_nxt   = r_bit_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (w_not_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + 1'b1;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_tx_ready   = r_tx_ready;
  assign eo_uart_tx   = r_tx;
  assign o_fifo_count = r_count;
  assign o_busy       = w_not_empty || (r_state != ST_IDLE);
  assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_only_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_only_fifo                                       |
// | Description : Directed bench for uart_tx_only_fifo. Three instances:     |
// |               default rate (173 clk/bit), a fast one (10 clk/bit) for    |
// |               the long burst/overflow sequences, and 9600 baud.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_tx_only_fifo;

  // Clocks per bit, worked out by hand from 20 MHz / baud (truncated).
  localparam int DIV_A = 173;   // 115200 baud
  localparam int DIV_B = 10;    // 2000000 baud
  localparam int DIV_C = 2083;  // 9600 baud

  logic       clk_20mhz = 1'b0;
  int         cyc = 0;
  logic [2:0] rstn;
  logic [2:0] valid;
  logic [7:0] data [3];

  logic       ready_a, tx_a, busy_a, ovf_a;
  logic       ready_b, tx_b, busy_b, ovf_b;
  logic       ready_c, tx_c, busy_c, ovf_c;
  logic [6:0] cnt_a, cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  // Receiver results per instance
  logic [7:0] qa[$], qb[$], qc[$];
  int         sa[$], sb[$], sc[$];
  int         bad_stop [3];
  int         epoch [3];

  always #5 clk_20mhz = ~clk_20mhz;

  // Cycle index: value N after rising edge N
  always @(posedge clk_20mhz) cyc <= cyc + 1;

  uart_tx_only_fifo u_dut_a (
    .i_clk_20mhz (clk_20mhz), .i_rstn_20mhz (rstn[0]),
    .i_tx_data (data[0]), .i_tx_valid (valid[0]),
    .o_tx_ready (ready_a), .eo_uart_tx (tx_a), .o_fifo_count (cnt_a),
    .o_busy (busy_a), .o_overflow (ovf_a)
  );

  uart_tx_only_fifo #(.parm_BAUD (2000000)) u_dut_b (
    .i_clk_20mhz (clk_20mhz), .i_rstn_20mhz (rstn[1]),
    .i_tx_data (data[1]), .i_tx_valid (valid[1]),
    .o_tx_ready (ready_b), .eo_uart_tx (tx_b), .o_fifo_count (cnt_b),
    .o_busy (busy_b), .o_overflow (ovf_b)
  );

  uart_tx_only_fifo #(.parm_BAUD (9600)) u_dut_c (
    .i_clk_20mhz (clk_20mhz), .i_rstn_20mhz (rstn[2]),
    .i_tx_data (data[2]), .i_tx_valid (valid[2]),
    .o_tx_ready (ready_c), .eo_uart_tx (tx_c), .o_fifo_count (cnt_c),
    .o_busy (busy_c), .o_overflow (ovf_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int k);
    case (k)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  // Called on the falling edge after the start bit is seen; samples bit centres.
  task automatic rx_frame(input int k, input int div, output logic [7:0] b, output logic ok);
    ok = 1'b1;
    b  = 8'h00;
    repeat (div / 2) @(negedge clk_20mhz);
    if (line_of(k) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk_20mhz);
      b[i] = line_of(k);
    end
    repeat (div) @(negedge clk_20mhz);
    if (line_of(k) !== 1'b1) ok = 1'b0;
  endtask

  // Enqueue one byte on instance k; call on a falling edge, returns one later.
  task automatic push(input int k, input logic [7:0] b);
    valid[k] = 1'b1;
    data[k]  = b;
    @(negedge clk_20mhz);
    valid[k] = 1'b0;
  endtask

  initial begin : rx_a
    logic [7:0] b;
    logic       ok;
    int         st, ep;
    forever begin
      @(negedge clk_20mhz);
      if (tx_a === 1'b0) begin
        st = cyc; ep = epoch[0];
        rx_frame(0, DIV_A, b, ok);
        if (ep == epoch[0]) begin
          qa.push_back(b); sa.push_back(st);
          if (!ok) bad_stop[0]++;
        end
      end
    end
  end

  initial begin : rx_b
    logic [7:0] b;
    logic       ok;
    int         st, ep;
    forever begin
      @(negedge clk_20mhz);
      if (tx_b === 1'b0) begin
        st = cyc; ep = epoch[1];
        rx_frame(1, DIV_B, b, ok);
        if (ep == epoch[1]) begin
          qb.push_back(b); sb.push_back(st);
          if (!ok) bad_stop[1]++;
        end
      end
    end
  end

  initial begin : rx_c
    logic [7:0] b;
    logic       ok;
    int         st, ep;
    forever begin
      @(negedge clk_20mhz);
      if (tx_c === 1'b0) begin
        st = cyc; ep = epoch[2];
        rx_frame(2, DIV_C, b, ok);
        if (ep == epoch[2]) begin
          qc.push_back(b); sc.push_back(st);
          if (!ok) bad_stop[2]++;
        end
      end
    end
  end

  initial begin : main
    int n, m, s, r, t;
    rstn  = 3'b000;
    valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      data[k] = 8'h00; bad_stop[k] = 0; epoch[k] = 0;
    end
    repeat (3) @(negedge clk_20mhz);

    // Reset state
    check("rst_tx", tx_a, 1);
    check("rst_ready", ready_a, 1);
    check("rst_count", cnt_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ovf", ovf_a, 0);
    rstn = 3'b111;
    repeat (2) @(negedge clk_20mhz);

    // Single byte 0x41 at 173 clocks per bit
    push(0, 8'h41); n = cyc;
    check("a_cnt_n", cnt_a, 1);
    check("a_tx_n", tx_a, 1);
    @(negedge clk_20mhz);
    check("a_tx_start", tx_a, 0);
    check("a_cnt_pop", cnt_a, 0);
    check("a_busy_run", busy_a, 1);
    repeat (1729) @(negedge clk_20mhz);
    check("a_busy_stop", busy_a, 1);
    check("a_tx_stop", tx_a, 1);
    @(negedge clk_20mhz);
    check("a_busy_end", busy_a, 0);
    check("a_nframes", qa.size(), 1);
    check("a_byte", (qa.size() > 0) ? int'(qa[0]) : -1, 32'h41);
    check("a_start_cyc", (sa.size() > 0) ? sa[0] : -1, n + 1);

    // Feeder burst of 34 bytes on the fast instance
    check("b_ready_pre", ready_b, 1);
    n = 0;
    for (int i = 0; i < 34; i++) begin
      push(1, 8'h30 + 8'(i));
      if (i == 0) n = cyc;
      if (i == 30) check("b_ready_c30", ready_b, 1);
      if (i == 31) check("b_ready_c31", ready_b, 0);
      if (i == 33) check("b_cnt_peak", cnt_b, 33);
    end
    repeat (267) @(negedge clk_20mhz);
    check("b_cnt_31", cnt_b, 31);
    check("b_ready_31", ready_b, 0);
    @(negedge clk_20mhz);
    check("b_cnt_30", cnt_b, 30);
    check("b_ready_30", ready_b, 1);
    repeat (3109) @(negedge clk_20mhz);
    check("b_burst_idle", busy_b, 0);
    check("b_burst_n", qb.size(), 34);
    for (int i = 0; i < 34; i++) begin
      check("b_burst_byte", (i < qb.size()) ? int'(qb[i]) : -1, 32'h30 + i);
      check("b_burst_start", (i < sb.size()) ? sb[i] : -1, n + 1 + 100 * i);
    end

    // Overflow: 66 writes while idle, the last one is dropped
    qb.delete(); sb.delete();
    check("b_ovf_pre", ovf_b, 0);
    m = 0;
    for (int i = 0; i < 66; i++) begin
      push(1, 8'h80 + 8'(i));
      if (i == 0) m = cyc;
      if (i == 64) begin
        check("b_cnt_full", cnt_b, 64);
        check("b_ovf_64", ovf_b, 0);
      end
      if (i == 65) begin
        check("b_cnt_drop", cnt_b, 64);
        check("b_ovf_set", ovf_b, 1);
        check("b_ready_full", ready_b, 0);
      end
    end
    repeat (6500) @(negedge clk_20mhz);
    check("b_ovf_sticky", ovf_b, 1);
    check("b_ovf_idle", busy_b, 0);
    check("b_ovf_nframes", qb.size(), 65);
    for (int i = 0; i < 65; i++) begin
      check("b_ovf_byte", (i < qb.size()) ? int'(qb[i]) : -1, 32'h80 + i);
      check("b_ovf_start", (i < sb.size()) ? sb[i] : -1, m + 1 + 100 * i);
    end

    // Back-to-back boundary and simultaneous write/pop at count 1
    qb.delete(); sb.delete();
    push(1, 8'hA5); s = cyc;
    repeat (99) @(negedge clk_20mhz);
    push(1, 8'h5A);
    check("bb_tx_stop", tx_b, 1);
    check("bb_cnt", cnt_b, 1);
    @(negedge clk_20mhz);
    check("bb_tx_next", tx_b, 0);
    check("bb_cnt_pop", cnt_b, 0);
    repeat (48) @(negedge clk_20mhz);
    push(1, 8'hC3);
    check("wp_cnt_pre", cnt_b, 1);
    repeat (50) @(negedge clk_20mhz);
    push(1, 8'h3C);
    check("wp_cnt_same", cnt_b, 1);
    check("wp_tx_start", tx_b, 0);
    repeat (250) @(negedge clk_20mhz);
    check("bb_nframes", qb.size(), 4);
    check("bb_byte0", (qb.size() > 0) ? int'(qb[0]) : -1, 32'hA5);
    check("bb_byte1", (qb.size() > 1) ? int'(qb[1]) : -1, 32'h5A);
    check("bb_byte2", (qb.size() > 2) ? int'(qb[2]) : -1, 32'hC3);
    check("bb_byte3", (qb.size() > 3) ? int'(qb[3]) : -1, 32'h3C);
    for (int i = 0; i < 4; i++) begin
      check("bb_start", (i < sb.size()) ? sb[i] : -1, s + 1 + 100 * i);
    end

    // Reset during bit 4 of 0x55 with five bytes queued
    qb.delete(); sb.delete();
    push(1, 8'h55); r = cyc;
    for (int i = 1; i <= 5; i++) push(1, 8'(i));
    check("rm_cnt_q", cnt_b, 5);
    repeat (40) @(negedge clk_20mhz);
    check("rm_tx_bit3", tx_b, 0);
    repeat (10) @(negedge clk_20mhz);
    epoch[1]++;
    rstn[1] = 1'b0;
    #1;
    check("rm_tx_high", tx_b, 1);
    check("rm_cnt_zero", cnt_b, 0);
    check("rm_ovf_clr", ovf_b, 0);
    check("rm_busy", busy_b, 0);
    check("rm_ready", ready_b, 1);
    @(negedge clk_20mhz);
    rstn[1] = 1'b1;
    repeat (300) @(negedge clk_20mhz);
    check("rm_no_frames", qb.size(), 0);
    check("rm_idle_tx", tx_b, 1);
    push(1, 8'h0D); t = cyc;
    repeat (110) @(negedge clk_20mhz);
    check("rm_post_n", qb.size(), 1);
    check("rm_post_byte", (qb.size() > 0) ? int'(qb[0]) : -1, 32'h0D);
    check("rm_post_start", (sb.size() > 0) ? sb[0] : -1, t + 1);

    // 9600 baud: 0x0A gives start+bit0 low (4166 clocks), bit1 high
    push(2, 8'h0A); n = cyc;
    @(negedge clk_20mhz);
    check("c_tx_start", tx_c, 0);
    repeat (4165) @(negedge clk_20mhz);
    check("c_tx_bit0_end", tx_c, 0);
    @(negedge clk_20mhz);
    check("c_tx_bit1", tx_c, 1);
    repeat (16663) @(negedge clk_20mhz);
    check("c_busy_stop", busy_c, 1);
    @(negedge clk_20mhz);
    check("c_busy_end", busy_c, 0);
    check("c_nframes", qc.size(), 1);
    check("c_byte", (qc.size() > 0) ? int'(qc[0]) : -1, 32'h0A);
    check("c_start_cyc", (sc.size() > 0) ? sc[0] : -1, n + 1);

    check("a_stop_bits", bad_stop[0], 0);
    check("b_stop_bits", bad_stop[1], 0);
    check("c_stop_bits", bad_stop[2], 0);
    check("a_ovf_never", ovf_a, 0);
    check("c_ovf_never", ovf_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
